shift_result_stage: RTL

SHIFT_RESULT_STAGE -- requirements
Module: shift_result_stage

---
 rtl/kgp_alu_pkg.sv | 13 +
 rtl/shift_result_stage_flag_gen.sv | 21 ++
 rtl/shift_result_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/kgp_alu_pkg.sv
// Shared ALU definitions: default datapath width and the architectural flags record.
package kgp_alu_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef struct packed {
    logic zero;
    logic carry;
    logic sign;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/shift_result_stage_flag_gen.sv
// Combinational flag derivation for one result word, used when a flag-writing beat retires.
module flag_gen
  import kgp_alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] result,
  input  logic              carry,
  input  logic              ovf,
  output flags_t            flags
);

  always_comb begin
    flags       = '0;
    flags.zero  = (result == '0);
    flags.carry = carry;
    flags.sign  = result[DATA_W-1];
    flags.ovf   = ovf;
  end

endmodule

// File: rtl/shift_result_stage.sv
// Two-entry (main + skid) result buffer between shifter/ALU and writeback, owning the flags register.
// Optional stall counter port perf_stall_cnt is built when RESULT_STAGE_PERF_EN is defined.
module shift_result_stage
  import kgp_alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_ovf,
  input  logic              in_upd_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  input  logic              flush,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              flag_sign,
  output logic              flag_ovf
`ifdef RESULT_STAGE_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              ovf;
    logic              upd;
  } entry_t;

  entry_t main_q, skid_q, main_d, skid_d, in_entry;
  logic   main_valid, skid_valid, main_valid_d, skid_valid_d;
  logic   ready_q;
  logic   accept, handoff;
  flags_t flags_q, flags_new;

  assign in_entry = '{result: in_result, carry: in_carry, ovf: in_ovf, upd: in_upd_flags};
  assign accept   = in_valid & ready_q & ~flush;
  assign handoff  = main_valid & out_ready;

  // Hand-off first frees main, so a same-cycle accept lands in main and order is preserved.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (handoff) begin
        main_d       = skid_q;
        main_valid_d = skid_valid;
        skid_valid_d = 1'b0;
      end
      if (accept) begin
        if (!main_valid_d) begin
          main_d       = in_entry;
          main_valid_d = 1'b1;
        end else begin
          skid_d       = in_entry;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
    .result (main_q.result),
    .carry  (main_q.carry),
    .ovf    (main_q.ovf),
    .flags  (flags_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      flags_q    <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
      ready_q    <= ~skid_valid_d;
      if (handoff && main_q.upd && !flush)
        flags_q <= flags_new;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = main_valid;
  assign out_result = main_q.result;
  assign flag_zero  = flags_q.zero;
  assign flag_carry = flags_q.carry;
  assign flag_sign  = flags_q.sign;
  assign flag_ovf   = flags_q.ovf;

`ifdef RESULT_STAGE_PERF_EN
  // Saturating count of cycles where upstream is blocked by a full buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_stall_cnt <= '0;
    else if (in_valid && !ready_q && perf_stall_cnt != 16'hFFFF)
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end
`else
  // Stall counter not built in this configuration.
`endif

endmodule
